// File: rtl/sdft_sched_pkg.sv
// sdft_sched_pkg: shared FSM state type and counter width helper for the sdft tick scheduler.
package sdft_sched_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_SOB, SWEEP} state_t;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sdft_tick_scheduler_if.sv
// sdft_tick_scheduler_if: sample stream, sdft control/status and scheduler status bundle.
interface sdft_tick_scheduler_if #(
    parameter int DW    = 16,
    parameter int IW    = 8,
    parameter int CNT_W = 16
);
    logic             s_valid_i;
    logic [DW-1:0]    s_data_i;
    logic             s_ready_o;
    logic             sample_tick_o;
    logic [DW-1:0]    data_o;
    logic             sdft_sob_i;
    logic             sdft_eob_i;
    logic             sdft_valid_i;
    logic [IW-1:0]    bin_idx_o;
    logic             busy_o;
    logic             seq_err_o;
    logic [CNT_W-1:0] overrun_cnt_o;
    modport slave (
        input  s_valid_i, s_data_i, sdft_sob_i, sdft_eob_i, sdft_valid_i,
        output s_ready_o, sample_tick_o, data_o, bin_idx_o, busy_o, seq_err_o, overrun_cnt_o
    );
    modport master (
        output s_valid_i, s_data_i, sdft_sob_i, sdft_eob_i, sdft_valid_i,
        input  s_ready_o, sample_tick_o, data_o, bin_idx_o, busy_o, seq_err_o, overrun_cnt_o
    );
endinterface

// File: rtl/sdft_sched_in_buf.sv
// sdft_sched_in_buf: one-entry sample buffer with registered ready.
// SDFT_SCHED_DROP_EN: always ready, newest sample overwrites a full buffer and bumps overrun_cnt.
module sdft_sched_in_buf #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    input  logic             take,
    output logic             s_ready,
    output logic             buf_full,
    output logic [DW-1:0]    buf_data,
    output logic [CNT_W-1:0] overrun_cnt
);
    logic acc;
    assign acc = s_valid && s_ready;
`ifdef SDFT_SCHED_DROP_EN
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            s_ready     <= 1'b0;
            buf_full    <= 1'b0;
            buf_data    <= '0;
            overrun_cnt <= '0;
        end else begin
            s_ready  <= 1'b1;
            buf_full <= acc || (buf_full && !take);
            if (acc) buf_data <= s_data;
            // A sample landing in the tick cycle refills the slot just freed, so it is not a drop.
            if (acc && buf_full && !take && overrun_cnt != '1) overrun_cnt <= overrun_cnt + CNT_W'(1);
        end
`else
    logic full_n;
    assign full_n = acc || (buf_full && !take);
    assign overrun_cnt = '0;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            s_ready  <= 1'b0;
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            s_ready  <= !full_n;
            buf_full <= full_n;
            if (acc) buf_data <= s_data;
        end
`endif
endmodule

// File: rtl/sdft_tick_scheduler.sv
// sdft_tick_scheduler: paces sample ticks into sdft, tags output bins, flags core protocol errors.
// SDFT_SCHED_DROP_EN selects overwrite-on-full input buffering instead of backpressure.
module sdft_tick_scheduler
    import sdft_sched_pkg::*;
#(
    parameter int N       = 256,
    parameter int DW      = 16,
    parameter int MIN_GAP = N + 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input logic clk_i,
    input logic rst_i,
    sdft_tick_scheduler_if.slave bus
);
    localparam int IW = cw(N);
    localparam int BW = cw(N + 1);
    localparam int GW = cw(MIN_GAP + 1);
    localparam int TW = cw(TIMEOUT + 1);
    state_t state, state_n;
    logic buf_full, gap_ok, to_exp, tick, sob_hit, err_set, seq_err;
    logic [DW-1:0] buf_data, data_q;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] beats;

    sdft_sched_in_buf #(.DW(DW), .CNT_W(CNT_W)) u_in_buf (
        .clk_i, .rst_i,
        .s_valid(bus.s_valid_i), .s_data(bus.s_data_i), .take(tick),
        .s_ready(bus.s_ready_o), .buf_full, .buf_data, .overrun_cnt(bus.overrun_cnt_o)
    );

    assign gap_ok = gap_cnt >= GW'(MIN_GAP - 1);
    assign to_exp = to_cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_n;

    always_comb
        state_n = (state == IDLE) ? ((buf_full && gap_ok) ? WAIT_SOB : IDLE) :
                  (state == WAIT_SOB) ? (bus.sdft_sob_i ? SWEEP : (to_exp ? IDLE : WAIT_SOB)) :
                  (bus.sdft_eob_i ? IDLE : SWEEP);

    always_comb begin
        tick              = state == IDLE && buf_full && gap_ok;
        sob_hit           = state == WAIT_SOB && bus.sdft_sob_i;
        bus.sample_tick_o = tick;
        bus.busy_o        = state != IDLE;
        bus.bin_idx_o     = sob_hit ? '0 : beats[IW-1:0];
        bus.data_o        = tick ? buf_data : data_q;
    end

    // Each term is one way the core can break the sob..eob contract.
    assign err_set = (state == IDLE && bus.sdft_valid_i) ||
                     (state == WAIT_SOB && (bus.sdft_eob_i || (!bus.sdft_sob_i && to_exp))) ||
                     (state == SWEEP && (bus.sdft_sob_i || (bus.sdft_eob_i && beats != BW'(N - 1))));
    assign bus.seq_err_o = seq_err;

    // gap_cnt starts saturated so the first sample after reset ticks without waiting.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            gap_cnt <= GW'(MIN_GAP);
            to_cnt  <= '0;
            beats   <= '0;
            data_q  <= '0;
            seq_err <= 1'b0;
        end else begin
            gap_cnt <= tick ? '0 : (gap_cnt < GW'(MIN_GAP)) ? gap_cnt + GW'(1) : gap_cnt;
            to_cnt  <= tick ? TW'(1) : (state == WAIT_SOB) ? to_cnt + TW'(1) : to_cnt;
            beats   <= (state_n != SWEEP) ? '0 : sob_hit ? BW'(1) :
                       (bus.sdft_valid_i && beats != BW'(N)) ? beats + BW'(1) : beats;
            if (tick) data_q <= buf_data;
            seq_err <= seq_err || err_set;
        end
endmodule
